axis_decimator: RTL and testbench

- Downstream stage for the FIR filter's AXI4-Stream output (16-bit Q1.15).
- Reduces the sample rate by a runtime-selectable power-of-two ratio.
- Two modes: keep the last sample of each group, or output the rounded group average.
- Single registered output stage with full AXI4-Stream backpressure toward the filter; counts emitted samples for status readout.

---
 rtl/axis_decimator.sv | 129 ++++++++++++
 tb/tb_axis_decimator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axis_decimator.sv
// axis_decimator
//   Power-of-two sample-rate reducer for the FIR filter's AXI4-Stream output.
//   Each group of R = 2^k accepted input beats yields one output beat. The
//   output is either the last sample of the group (keep mode) or the rounded
//   group average (average mode). A single registered output stage provides
//   full backpressure toward the filter.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   decim_log2     decimation exponent k (clamped to MAX_LOG2), latched per group
//   avg_mode       0 = keep last sample, 1 = rounded average; latched per group
//   s_axis_*       input stream (signed Q1.15 samples)
//   m_axis_*       decimated output stream
//   out_count      output beats accepted downstream (wraps)
//   group_phase    input beats accepted so far in the current group
module axis_decimator #(
  parameter int DATA_W   = 16,
  parameter int MAX_LOG2 = 4,
  parameter int ACC_W    = DATA_W + MAX_LOG2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 decim_log2,
  input  logic                       avg_mode,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic signed [DATA_W-1:0]   s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic signed [DATA_W-1:0]   m_axis_tdata,
  output logic [31:0]                out_count,
  output logic [MAX_LOG2-1:0]        group_phase
);

  localparam logic [2:0] K_MAX = 3'(MAX_LOG2);

  function automatic logic [2:0] clamp_k(input logic [2:0] k);
    return (k > K_MAX) ? K_MAX : k;
  endfunction

  // Phase value of the R-th (final) beat of a group: R-1.
  function automatic logic [MAX_LOG2-1:0] last_phase(input logic [2:0] k);
    logic [MAX_LOG2:0] r;
    r = (MAX_LOG2+1)'(1) << k;
    return MAX_LOG2'(r - (MAX_LOG2+1)'(1));
  endfunction

  // Round-half-up average: add half an LSB of the result, then arithmetic
  // shift. The accumulator has MAX_LOG2 bits of headroom, so neither the
  // bias addition nor the truncation to DATA_W can overflow.
  function automatic logic signed [DATA_W-1:0] round_avg(
    input logic signed [ACC_W-1:0] sum,
    input logic [2:0]              k
  );
    logic signed [ACC_W-1:0] bias;
    logic signed [ACC_W-1:0] t;
    bias = (k == 3'd0) ? '0 : ACC_W'(1) << (k - 3'd1);
    t    = (sum + bias) >>> k;
    return t[DATA_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] acc_p0;
  logic [2:0]              k_lat_p0;
  logic                    avg_lat_p0;

  logic                    accept;
  logic                    first_beat;
  logic [2:0]              k_cur;
  logic                    avg_cur;
  logic signed [ACC_W-1:0] samp_ext;
  logic signed [ACC_W-1:0] sum_nxt;
  logic                    done;

  assign s_axis_tready = ~rst & (~m_axis_tvalid | m_axis_tready);

  always_comb begin
    accept     = s_axis_tvalid & s_axis_tready;
    first_beat = (group_phase == '0);
    // The first beat of a group uses the live config; later beats use the
    // copy latched when that first beat was accepted.
    k_cur      = first_beat ? clamp_k(decim_log2) : k_lat_p0;
    avg_cur    = first_beat ? avg_mode : avg_lat_p0;
    samp_ext   = {{MAX_LOG2{s_axis_tdata[DATA_W-1]}}, s_axis_tdata};
    sum_nxt    = (first_beat ? '0 : acc_p0) + samp_ext;
    done       = accept && (group_phase == last_phase(k_cur));
  end

  // Stage p0: group accumulation, config latch and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0        <= '0;
      k_lat_p0      <= '0;
      avg_lat_p0    <= 1'b0;
      group_phase   <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      out_count     <= '0;
    end else begin
      if (accept) begin
        if (first_beat) begin
          k_lat_p0   <= k_cur;
          avg_lat_p0 <= avg_cur;
        end
        if (done) begin
          group_phase  <= '0;
          acc_p0       <= '0;
          m_axis_tdata <= avg_cur ? round_avg(sum_nxt, k_cur) : s_axis_tdata;
        end else begin
          group_phase <= group_phase + MAX_LOG2'(1);
          acc_p0      <= sum_nxt;
        end
      end

      if (m_axis_tvalid && m_axis_tready) begin
        out_count <= out_count + 32'd1;
      end

      // A completing group can only be accepted when the register is empty
      // or draining this edge, so loading always wins over clearing.
      if (done) begin
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_decimator.sv
module tb_axis_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  decim_log2;
  logic        avg_mode;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] s_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] m_axis_tdata;
  logic [31:0] out_count;
  logic [3:0]  group_phase;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  axis_decimator dut (
    .clk           (clk),
    .rst           (rst),
    .decim_log2    (decim_log2),
    .avg_mode      (avg_mode),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .out_count     (out_count),
    .group_phase   (group_phase)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: every transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      chk("out_unexpected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("out_data", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
    end
  end

  // Drive a beat and return #1 after the edge that accepts it.
  task automatic send(input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_axis_tready;
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; decim_log2 = 3'd0; avg_mode = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_count", out_count, 32'd0);
    chk("rst_phase", 32'(group_phase), 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    rst = 1'b0;
    idle(1);

    // 1: k=0 keep, back-to-back, one-cycle latency
    exp_q.push_back(16'h7FFF); send(16'h7FFF);
    chk("t1_v0", 32'(m_axis_tvalid), 32'd1); chk("t1_d0", 32'(m_axis_tdata), 32'h7FFF);
    exp_q.push_back(16'h8000); send(16'h8000);
    chk("t1_v1", 32'(m_axis_tvalid), 32'd1); chk("t1_d1", 32'(m_axis_tdata), 32'h8000);
    exp_q.push_back(16'h1234); send(16'h1234);
    chk("t1_v2", 32'(m_axis_tvalid), 32'd1); chk("t1_d2", 32'(m_axis_tdata), 32'h1234);
    idle(2);
    chk("t1_count", out_count, 32'd3);
    chk("t1_drained", 32'(m_axis_tvalid), 32'd0);

    // 2: k=2 keep, group_phase cycles 1,2,3,0
    decim_log2 = 3'd2;
    for (int g = 0; g < 2; g++) begin
      for (int i = 1; i <= 4; i++) begin
        if (i == 4) exp_q.push_back(16'(g * 4 + i));
        send(16'(g * 4 + i));
        chk("t2_phase", 32'(group_phase), 32'(i % 4));
        if (i < 4 && g == 0) chk("t2_novalid", 32'(m_axis_tvalid), 32'd0);
      end
    end
    idle(2);
    chk("t2_count", out_count, 32'd5);

    // 3: k=2 average, extremes and rounding
    avg_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin if (i == 3) exp_q.push_back(16'h7FFF); send(16'h7FFF); end
    for (int i = 0; i < 4; i++) begin if (i == 3) exp_q.push_back(16'h8000); send(16'h8000); end
    send(16'd1); send(16'd2); send(16'd3); exp_q.push_back(16'h0003); send(16'd4);
    send(16'hFFFF); send(16'hFFFF); send(16'hFFFF); exp_q.push_back(16'hFFFF); send(16'hFFFE);
    idle(2);
    chk("t3_count", out_count, 32'd9);

    // 4: k=0 output hold under backpressure
    avg_mode = 1'b0; decim_log2 = 3'd0; m_axis_tready = 1'b0;
    exp_q.push_back(16'h00A1); exp_q.push_back(16'h00B2);
    exp_q.push_back(16'h00C3); exp_q.push_back(16'h00D4);
    send(16'h00A1);
    s_axis_tdata = 16'h00B2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_ready", 32'(s_axis_tready), 32'd0);
      chk("t4_hold_valid", 32'(m_axis_tvalid), 32'd1);
      chk("t4_hold_data", 32'(m_axis_tdata), 32'h00A1);
    end
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    send(16'h00B2); send(16'h00C3); send(16'h00D4);
    idle(3);
    chk("t4_count", out_count, 32'd13);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: config change mid-group takes effect on the next group
    decim_log2 = 3'd2;
    send(16'd10); send(16'd11);
    decim_log2 = 3'd1;
    send(16'd12);
    chk("t5_phase3", 32'(group_phase), 32'd3);
    chk("t5_novalid", 32'(m_axis_tvalid), 32'd0);
    exp_q.push_back(16'd13); send(16'd13);
    chk("t5_phase0", 32'(group_phase), 32'd0);
    chk("t5_valid", 32'(m_axis_tvalid), 32'd1);
    send(16'd20);
    chk("t5_g2_phase1", 32'(group_phase), 32'd1);
    exp_q.push_back(16'd21); send(16'd21);
    chk("t5_g2_phase0", 32'(group_phase), 32'd0);
    chk("t5_g2_data", 32'(m_axis_tdata), 32'd21);
    idle(2);

    // 6: reset mid-group discards the partial group
    decim_log2 = 3'd2; avg_mode = 1'b1;
    send(16'd1); send(16'd2); send(16'd3);
    chk("t6_phase_pre", 32'(group_phase), 32'd3);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("t6_rst_valid", 32'(m_axis_tvalid), 32'd0);
    chk("t6_rst_phase", 32'(group_phase), 32'd0);
    chk("t6_rst_count", out_count, 32'd0);
    send(16'd4); send(16'd4); send(16'd4);
    exp_q.push_back(16'h0004); send(16'd4);
    chk("t6_data", 32'(m_axis_tdata), 32'h0004);
    idle(3);
    chk("t6_count", out_count, 32'd1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
